// File: rtl/multicycle_cobra_core.sv
// Multi-cycle cobra core: FETCH / EXEC / WAIT_IN sequencer, 32-entry register file and ALU.
// Optional COBRA_HALT_EN adds a `halted` port; a jump-to-self then parks the core in HALT.
module multicycle_cobra_core #(
   parameter int XLEN = 32,
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_data,
   output logic [XLEN-1:0] out_data,
`ifdef COBRA_HALT_EN
   output logic            out_valid,
   output logic            halted
`else
   output logic            out_valid
`endif
);

   localparam int SH_W = $clog2(XLEN);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

   state_t            state_reg, state_next;
   logic [PC_W-1:0]   pc_reg, pc_next;
   logic [31:0]       ir_reg;
   logic [XLEN-1:0]   rf_q [32];

   logic              ir_b, ir_c;
   logic [1:0]        ir_ws;
   logic [4:0]        ir_op, ir_ra1, ir_ra2, ir_wa;
   logic [7:0]        ir_off;
   logic [XLEN-1:0]   rd1, rd2, alu_res, imm_sx, rf_wdata;
   logic              alu_flag, branch_take, rf_we, out_load;
   logic [PC_W-1:0]   off_pc;

   assign ir_b   = ir_reg[31];
   assign ir_c   = ir_reg[30];
   assign ir_ws  = ir_reg[29:28];
   assign ir_op  = ir_reg[27:23];
   assign ir_ra1 = ir_reg[22:18];
   assign ir_ra2 = ir_reg[17:13];
   assign ir_off = ir_reg[12:5];
   assign ir_wa  = ir_reg[4:0];

   assign imm_sx    = XLEN'($signed(ir_reg[27:5]));
   assign off_pc    = PC_W'($signed(ir_off));
   assign imem_addr = pc_reg;

   // x0 is hardwired; only entries 1..31 hold state, so writes to WA=0 vanish.
   assign rf_q[0] = '0;
   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_rf
         logic [XLEN-1:0] r_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_reg <= '0;
            else if (rf_we && ir_wa == 5'(gi))
               r_reg <= rf_wdata;
         end
         assign rf_q[gi] = r_reg;
      end
   endgenerate

   assign rd1 = rf_q[ir_ra1];
   assign rd2 = rf_q[ir_ra2];

   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      case (ir_op)
         5'b00000: alu_res = rd1 + rd2;
         5'b01000: alu_res = rd1 - rd2;
         5'b00001: alu_res = rd1 << rd2[SH_W-1:0];
         5'b00010: alu_res = {{(XLEN-1){1'b0}}, $signed(rd1) < $signed(rd2)};
         5'b00011: alu_res = {{(XLEN-1){1'b0}}, rd1 < rd2};
         5'b00100: alu_res = rd1 ^ rd2;
         5'b00101: alu_res = rd1 >> rd2[SH_W-1:0];
         5'b01101: alu_res = $unsigned($signed(rd1) >>> rd2[SH_W-1:0]);
         5'b00110: alu_res = rd1 | rd2;
         5'b00111: alu_res = rd1 & rd2;
         5'b11000: alu_flag = (rd1 == rd2);
         5'b11001: alu_flag = (rd1 != rd2);
         5'b11100: alu_flag = ($signed(rd1) < $signed(rd2));
         5'b11101: alu_flag = ($signed(rd1) >= $signed(rd2));
         5'b11110: alu_flag = (rd1 < rd2);
         5'b11111: alu_flag = (rd1 >= rd2);
         default: ;
      endcase
   end

   assign branch_take = ir_b | (ir_c & alu_flag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= S_FETCH;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      case (state_reg)
         S_FETCH: if (imem_ack) state_next = S_EXEC;
         S_EXEC: begin
            if (ir_ws == 2'b01 && !in_valid) begin
               state_next = S_WAIT;
            end else begin
               pc_next    = branch_take ? pc_reg + off_pc : pc_reg + PC_ONE;
               state_next = S_FETCH;
`ifdef COBRA_HALT_EN
               if (ir_b && ir_off == 8'd0) state_next = S_HALT;
`endif
            end
         end
         S_WAIT: begin
            if (in_valid) begin
               pc_next    = pc_reg + PC_ONE;
               state_next = S_FETCH;
            end
         end
`ifdef COBRA_HALT_EN
         S_HALT: state_next = S_HALT;
`endif
         default: state_next = S_FETCH;
      endcase
   end

   // Handshake outputs are forced low while reset is held, not just after it.
   always_comb begin
      imem_req = 1'b0;
      in_ready = 1'b0;
      rf_we    = 1'b0;
      rf_wdata = '0;
      out_load = 1'b0;
      case (state_reg)
         S_FETCH: imem_req = 1'b1;
         S_EXEC: begin
            in_ready = (ir_ws == 2'b01);
            if (!(ir_ws == 2'b01 && !in_valid)) begin
               case (ir_ws)
                  2'b01: begin rf_we = 1'b1; rf_wdata = in_data; end
                  2'b10: begin rf_we = 1'b1; rf_wdata = imm_sx;  end
                  2'b11: begin rf_we = 1'b1; rf_wdata = alu_res; out_load = 1'b1; end
                  default: ;
               endcase
            end
         end
         S_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               rf_we    = 1'b1;
               rf_wdata = in_data;
            end
         end
         default: ;
      endcase
      if (rst) begin
         imem_req = 1'b0;
         in_ready = 1'b0;
      end
   end

`ifdef COBRA_HALT_EN
   assign halted = (state_reg == S_HALT);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg    <= '0;
         ir_reg    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         out_valid <= out_load;
         if (state_reg == S_FETCH && imem_ack)
            ir_reg <= imem_rdata;
         if (out_load)
            out_data <= alu_res;
      end
   end

endmodule

// File: tb/tb_multicycle_cobra_core.sv
// Scoreboard bench for multicycle_cobra_core: expected fetch addresses and results are
// queued per program and popped as the core fetches and strobes out_valid.
`timescale 1ns/1ps
module tb_multicycle_cobra_core;

   localparam int XLEN = 32;
   localparam int PC_W = 8;

   localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b01000, OP_SLL = 5'b00001,
                          OP_SLT = 5'b00010, OP_SLTU = 5'b00011, OP_XOR = 5'b00100,
                          OP_SRL = 5'b00101, OP_SRA = 5'b01101, OP_OR = 5'b00110,
                          OP_AND = 5'b00111, OP_EQ = 5'b11000, OP_NE = 5'b11001,
                          OP_UND = 5'b01010;
   localparam logic [31:0] JSELF = 32'h8000_0000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req, imem_ack, in_valid, in_ready, out_valid;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic [XLEN-1:0] in_data, out_data;
`ifdef COBRA_HALT_EN
   logic            halted;
`endif

   always #5 clk = ~clk;

   multicycle_cobra_core #(.XLEN(XLEN), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_data(out_data),
`ifdef COBRA_HALT_EN
      .out_valid(out_valid), .halted(halted)
`else
      .out_valid(out_valid)
`endif
   );

   int vectors = 0;
   int miscompares = 0;
   logic [31:0]     imem [256];
   logic [PC_W-1:0] exp_pc [$];
   logic [XLEN-1:0] exp_out [$];
   logic [XLEN-1:0] in_q [$];
   int              t_ack [$];
   int ack_dly = 0, in_gap = 0, stall_cnt = 0, cyc = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] enc(input logic b, input logic c, input logic [1:0] ws,
                                       input logic [4:0] op, input logic [4:0] ra1,
                                       input logic [4:0] ra2, input logic [7:0] off,
                                       input logic [4:0] wa);
      return {b, c, ws, op, ra1, ra2, off, wa};
   endfunction

   function automatic logic [31:0] li(input logic [4:0] wa, input logic [22:0] imm);
      return {4'b0010, imm, wa};
   endfunction

   function automatic logic [31:0] alu(input logic [4:0] op, input logic [4:0] ra1,
                                       input logic [4:0] ra2, input logic [4:0] wa);
      return enc(1'b0, 1'b0, 2'b11, op, ra1, ra2, 8'h00, wa);
   endfunction

   // Instruction memory with configurable wait states, input producer and output monitor,
   // all serviced on the falling edge so they never race the DUT's rising edge.
   initial begin
      int wait_cnt = 0, gap_cnt = 0;
      bit pend = 0, prev_ov = 0;
      logic [PC_W-1:0] first_addr = '0;
      imem_ack = 1'b0; imem_rdata = '0; in_valid = 1'b0; in_data = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (imem_req) begin
            if (wait_cnt == 0) first_addr = imem_addr;
            if (wait_cnt >= ack_dly) begin
               imem_ack   = 1'b1;
               imem_rdata = imem[imem_addr];
               if (ack_dly > 0) chk("addr_hold", imem_addr, first_addr);
               if (exp_pc.size() > 0) chk("fetch_pc", imem_addr, exp_pc.pop_front());
               t_ack.push_back(cyc);
               wait_cnt = 0;
            end else begin
               imem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            if (wait_cnt > 0 && !rst) chk("req_hold", imem_req, 1);
            imem_ack = 1'b0;
            wait_cnt = 0;
         end

         if (rst) begin
            gap_cnt = 0; pend = 0; in_valid = 1'b0;
         end else begin
            if (pend) begin
               void'(in_q.pop_front());
               in_valid = 1'b0; pend = 0; gap_cnt = 0;
            end
            if (in_q.size() > 0 && !in_valid) begin
               if (gap_cnt >= in_gap) begin
                  in_valid = 1'b1; in_data = in_q[0];
               end else if (in_ready) begin
                  gap_cnt++;
               end
            end
            if (in_ready && !in_valid) stall_cnt++;
            if (in_valid && in_ready) pend = 1;
         end

         if (out_valid) begin
            chk("strobe_width", prev_ov, 0);
            if (exp_out.size() > 0) chk("out_data", out_data, exp_out.pop_front());
            else chk("out_unexpected", out_valid, 0);
         end
         prev_ov = out_valid;
      end
   end

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
   endtask

   // Caller holds rst high while loading the program and expected queues.
   task automatic run_prog();
      int n = 0;
      t_ack.delete();
      @(posedge clk); #1 rst = 1'b0;
      while ((exp_pc.size() != 0 || exp_out.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("prog_timeout", (n < 3000), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n_req, bad;
      repeat (2) @(negedge clk);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
`ifdef COBRA_HALT_EN
      chk("rst_halted", halted, 0);
`endif

      // Immediates then ADD, same-cycle ack.
      clear_imem();
      imem[0] = li(5'd1, 23'd5);
      imem[1] = li(5'd2, 23'h7FFFFD);
      imem[2] = alu(OP_ADD, 5'd1, 5'd2, 5'd3);
      imem[3] = JSELF;
      exp_pc  = '{8'd0, 8'd1, 8'd2, 8'd3};
      exp_out = '{32'd2};
      run_prog();
      chk("fetch3_latency", t_ack[3] - t_ack[0], 6);
      n_req = 0; bad = 0;
      repeat (20) begin
         @(negedge clk);
`ifdef COBRA_HALT_EN
         if (imem_req || !halted || in_ready) bad++;
`else
         if (imem_req) begin
            n_req++;
            if (imem_addr != 8'd3) bad++;
         end
`endif
      end
`ifdef COBRA_HALT_EN
      chk("halt_hold", bad, 0);
`else
      chk("refetch_count", n_req, 10);
      chk("refetch_addr", bad, 0);
`endif

      // Input stall: in_valid withheld for five in_ready cycles.
      rst = 1'b1; @(negedge clk);
      clear_imem();
      imem[0] = enc(1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 8'h00, 5'd4);
      imem[1] = alu(OP_ADD, 5'd4, 5'd0, 5'd5);
      imem[2] = JSELF;
      exp_pc  = '{8'd0, 8'd1, 8'd2};
      exp_out = '{32'hA5};
      in_q.push_back(32'hA5);
      in_gap = 5; stall_cnt = 0;
      run_prog();
      chk("stall_cycles", stall_cnt, 5);
      in_gap = 0;

      // Branches: taken/not-taken conditionals, B over C, wrap-around.
      rst = 1'b1; @(negedge clk);
      clear_imem();
      imem[0]   = li(5'd1, 23'd7);
      imem[1]   = li(5'd2, 23'd7);
      imem[2]   = enc(1'b1, 1'b1, 2'b00, OP_ADD, 5'd1, 5'd2, 8'h08, 5'd0);
      imem[10]  = enc(1'b0, 1'b1, 2'b00, OP_EQ, 5'd1, 5'd2, 8'hFC, 5'd0);
      imem[6]   = enc(1'b0, 1'b1, 2'b00, OP_NE, 5'd1, 5'd2, 8'hFC, 5'd0);
      imem[7]   = enc(1'b1, 1'b0, 2'b00, OP_ADD, 5'd0, 5'd0, 8'hF3, 5'd0);
      imem[250] = enc(1'b1, 1'b0, 2'b00, OP_ADD, 5'd0, 5'd0, 8'h0A, 5'd0);
      imem[4]   = enc(1'b0, 1'b0, 2'b00, OP_EQ, 5'd1, 5'd2, 8'h10, 5'd0);
      imem[5]   = enc(1'b1, 1'b0, 2'b00, OP_ADD, 5'd0, 5'd0, 8'h0F, 5'd0);
      imem[20]  = alu(OP_ADD, 5'd1, 5'd2, 5'd3);
      imem[21]  = JSELF;
      exp_pc  = '{8'd0, 8'd1, 8'd2, 8'd10, 8'd6, 8'd7, 8'd250, 8'd4, 8'd5, 8'd20, 8'd21};
      exp_out = '{32'd14};
      run_prog();

      // ALU sweep behind three imem wait states, including x0 writes and shift masking.
      rst = 1'b1; @(negedge clk);
      clear_imem();
      ack_dly  = 3;
      imem[0]  = li(5'd1, 23'h7FFFF0);
      imem[1]  = li(5'd2, 23'd3);
      imem[2]  = alu(OP_ADD, 5'd1, 5'd2, 5'd0);
      imem[3]  = alu(OP_ADD, 5'd0, 5'd2, 5'd3);
      imem[4]  = alu(OP_SUB, 5'd1, 5'd2, 5'd5);
      imem[5]  = alu(OP_SLL, 5'd1, 5'd2, 5'd5);
      imem[6]  = alu(OP_SLT, 5'd1, 5'd2, 5'd5);
      imem[7]  = alu(OP_SLTU, 5'd1, 5'd2, 5'd5);
      imem[8]  = alu(OP_XOR, 5'd1, 5'd2, 5'd5);
      imem[9]  = alu(OP_SRL, 5'd1, 5'd2, 5'd5);
      imem[10] = alu(OP_SRA, 5'd1, 5'd2, 5'd5);
      imem[11] = alu(OP_OR, 5'd1, 5'd2, 5'd5);
      imem[12] = alu(OP_AND, 5'd1, 5'd2, 5'd5);
      imem[13] = alu(OP_EQ, 5'd1, 5'd2, 5'd5);
      imem[14] = alu(OP_UND, 5'd1, 5'd2, 5'd5);
      imem[15] = alu(OP_ADD, 5'd2, 5'd2, 5'd2);
      imem[16] = alu(OP_ADD, 5'd2, 5'd0, 5'd5);
      imem[17] = li(5'd6, 23'd33);
      imem[18] = alu(OP_SLL, 5'd2, 5'd6, 5'd5);
      imem[19] = JSELF;
      for (int i = 0; i < 20; i++) exp_pc.push_back(PC_W'(i));
      exp_out = '{32'hFFFFFFF3, 32'd3, 32'hFFFFFFED, 32'hFFFFFF80, 32'd1, 32'd0,
                  32'hFFFFFFF3, 32'h1FFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF3, 32'd0,
                  32'd0, 32'd0, 32'd6, 32'd6, 32'd12};
      run_prog();
      ack_dly = 0;

      // Asynchronous reset while parked in WAIT_IN, then a clean rerun from address 0.
      rst = 1'b1; @(negedge clk);
      clear_imem();
      imem[0] = alu(OP_ADD, 5'd5, 5'd0, 5'd6);
      imem[1] = li(5'd5, 23'd9);
      imem[2] = alu(OP_ADD, 5'd5, 5'd0, 5'd7);
      imem[3] = enc(1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 8'h00, 5'd8);
      exp_pc  = '{8'd0, 8'd1, 8'd2, 8'd3};
      exp_out = '{32'd0, 32'd9};
      run_prog();
      chk("wait_in_ready", in_ready, 1);
      chk("wait_out_data", out_data, 32'd9);
      @(negedge clk); #2 rst = 1'b1; #1;
      chk("arst_in_ready", in_ready, 0);
      chk("arst_imem_req", imem_req, 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_out_valid", out_valid, 0);
      @(negedge clk);
      exp_pc  = '{8'd0, 8'd1, 8'd2, 8'd3};
      exp_out = '{32'd0, 32'd9};
      run_prog();
      chk("rerun_in_ready", in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
